// File: rtl/z80_sound_io.sv
// z80_sound_io: Z80-side I/O decode for the sound-command latch.
// Generates command read/clear/reply strobes, YM2610 select, the NMI
// (gated by an enable register) and four ROM bank registers.
// Optional feature macro: SOUND_BANK_EN (bank registers implemented when
// defined; tied to their reset values otherwise).
module z80_sound_io #(
  parameter logic [7:0] BANK0_RST = 8'h02,
  parameter logic [7:0] BANK1_RST = 8'h06,
  parameter logic [7:0] BANK2_RST = 8'h0E,
  parameter logic [7:0] BANK3_RST = 8'h1E
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] SDA,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nSDW,
  output logic        nSDZ80R,
  output logic        nSDZ80CLR,
  output logic        nSDZ80W,
  output logic        nYM_CS,
  output logic [1:0]  YM_A,
  output logic        nNMI,
  output logic [7:0]  BANK0,
  output logic [7:0]  BANK1,
  output logic [7:0]  BANK2,
  output logic [7:0]  BANK3
);

  // Only SDA[4:0] are decoded, so every port mirrors each 32 addresses.
  logic [4:0] port;
  logic       ior;
  logic       iow;
  logic       io_active;
  logic       armed;
  logic       lead;
  logic       nsdw_q;
  logic       nsdw_rise;
  logic       clr_pulse;
  logic       nmi_en;
  logic       nmi_pend;
  logic       en_set;
  logic       en_clr;
  logic       unused_sda;

  assign port      = SDA[4:0];
  assign ior       = ~nIORQ & ~nRD;
  assign iow       = ~nIORQ & ~nWR;
  assign io_active = ior | iow;
  assign unused_sda = ^SDA[7:5];

  // A cycle counts as new only once nIORQ has been sampled high since the
  // last detected cycle (or since reset), so an access that straddles reset
  // release is ignored and a one-clock nIORQ gap is enough to rearm.
  assign lead      = io_active & armed;
  assign en_set    = lead & iow & (port == 5'h08);
  assign en_clr    = lead & iow & (port == 5'h18);
  assign nsdw_rise = nSDW & ~nsdw_q;

  // Registered level strobes: low for as long as the qualifying cycle lasts.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      nSDZ80R   <= 1'b1;
      nSDZ80CLR <= 1'b1;
      nSDZ80W   <= 1'b1;
      nYM_CS    <= 1'b1;
      YM_A      <= 2'b00;
    end else begin
      nSDZ80R   <= ~(ior & (port == 5'h00));
      nSDZ80CLR <= ~(iow & (port == 5'h00));
      nSDZ80W   <= ~(iow & (port == 5'h0C));
      nYM_CS    <= ~(io_active & (port[4:2] == 3'b001));
      YM_A      <= (io_active & (port[4:2] == 3'b001)) ? SDA[1:0] : 2'b00;
    end
  end

  // Leading-edge arming, nSDW history and the delayed port-00-read edge.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      armed     <= 1'b0;
      nsdw_q    <= 1'b1;
      clr_pulse <= 1'b0;
    end else begin
      if (nIORQ)          armed <= 1'b1;
      else if (io_active) armed <= 1'b0;
      nsdw_q    <= nSDW;
      clr_pulse <= lead & ior & (port == 5'h00);
    end
  end

  // NMI enable/pending state; a new command (set) beats a read (clear).
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      nmi_en   <= 1'b0;
      nmi_pend <= 1'b0;
      nNMI     <= 1'b1;
    end else begin
      if (en_set)      nmi_en <= 1'b1;
      else if (en_clr) nmi_en <= 1'b0;
      if (nsdw_rise)      nmi_pend <= 1'b1;
      else if (clr_pulse) nmi_pend <= 1'b0;
      nNMI <= ~(nmi_pend & nmi_en);
    end
  end

`ifdef SOUND_BANK_EN
  logic       bank_ld;
  logic [7:0] bank_q [4];

  assign bank_ld = lead & ior & (port[4:2] == 3'b010);

  // Bank registers load from the upper address byte on a read of 08-0B.
  // NOTE: this is a four-entry flop file with distinct reset values, not a
  // RAM, so resetting every entry is intended and cheap.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      bank_q[0] <= BANK0_RST;
      bank_q[1] <= BANK1_RST;
      bank_q[2] <= BANK2_RST;
      bank_q[3] <= BANK3_RST;
    end else if (bank_ld) begin
      bank_q[SDA[1:0]] <= SDA[15:8];
    end
  end

  assign BANK0 = bank_q[0];
  assign BANK1 = bank_q[1];
  assign BANK2 = bank_q[2];
  assign BANK3 = bank_q[3];
`else
  logic unused_bank;

  assign unused_bank = ^SDA[15:8];
  assign BANK0 = BANK0_RST;
  assign BANK1 = BANK1_RST;
  assign BANK2 = BANK2_RST;
  assign BANK3 = BANK3_RST;
`endif

endmodule

// File: tb/tb_z80_sound_io.sv
// Self-checking bench for z80_sound_io: directed scenarios plus a randomized
// transaction stream checked against a transaction-level model.
module tb_z80_sound_io;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [15:0] SDA;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic        nSDW;
  logic        nSDZ80R;
  logic        nSDZ80CLR;
  logic        nSDZ80W;
  logic        nYM_CS;
  logic [1:0]  YM_A;
  logic        nNMI;
  logic [7:0]  BANK0;
  logic [7:0]  BANK1;
  logic [7:0]  BANK2;
  logic [7:0]  BANK3;

  int errors = 0;
  int checks = 0;

  // Transaction-level model state.
  bit         m_en;
  bit         m_pend;
  logic [7:0] m_bank [4];

  logic [3:0]  strb;
  logic [31:0] banks;
  logic [31:0] exp_banks;
  assign strb      = {nSDZ80R, nSDZ80CLR, nSDZ80W, nYM_CS};
  assign banks     = {BANK3, BANK2, BANK1, BANK0};
  assign exp_banks = {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};

  z80_sound_io dut (
    .CLK(CLK), .nRESET(nRESET), .SDA(SDA), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nSDW(nSDW), .nSDZ80R(nSDZ80R), .nSDZ80CLR(nSDZ80CLR),
    .nSDZ80W(nSDZ80W), .nYM_CS(nYM_CS), .YM_A(YM_A), .nNMI(nNMI),
    .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .BANK3(BANK3)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected {nSDZ80R,nSDZ80CLR,nSDZ80W,nYM_CS} from the port table.
  function automatic logic [3:0] exp_strb(input bit act, input bit rd, input logic [15:0] a);
    int p;
    p = int'(a) % 32;
    exp_strb = 4'b1111;
    if (act) begin
      if (rd && p == 0)       exp_strb[3] = 1'b0;
      if (!rd && p == 0)      exp_strb[2] = 1'b0;
      if (!rd && p == 12)     exp_strb[1] = 1'b0;
      if (p >= 4 && p <= 7)   exp_strb[0] = 1'b0;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle_bus();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic start_io(input bit rd, input logic [15:0] a);
    SDA = a; nIORQ = 1'b0; nRD = !rd; nWR = rd;
  endtask

  task automatic io_cycle(input bit rd, input logic [15:0] a, input int hold);
    start_io(rd, a);
    cyc(hold);
    idle_bus();
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0;
    m_bank[0] = 8'h02; m_bank[1] = 8'h06; m_bank[2] = 8'h0E; m_bank[3] = 8'h1E;
  endtask

  task automatic test_reset();
    nRESET = 1'b0; SDA = '0; nSDW = 1'b1; idle_bus();
    cyc(3);
    nRESET = 1'b1;
    cyc(10);
    model_reset();
    checks++; if (strb !== 4'b1111) begin errors++; $display("FAIL reset_strobes got=%b exp=1111", strb); end
    checks++; if (YM_A !== 2'b00) begin errors++; $display("FAIL reset_ym_a got=%b exp=00", YM_A); end
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL reset_nnmi got=%b exp=1", nNMI); end
    checks++; if (banks !== 32'h1E0E0602) begin errors++; $display("FAIL reset_banks got=%h exp=1e0e0602", banks); end
  endtask

  task automatic test_nmi_basic();
    int n;
    io_cycle(0, 16'h0008, 2); cyc(2);
    nSDW = 1'b0; cyc(3); nSDW = 1'b1;
    cyc(1);
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL nmi_lat1 got=%b exp=1", nNMI); end
    cyc(1);
    checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL nmi_lat2 got=%b exp=0", nNMI); end
    start_io(1, 16'h0000); cyc(1);
    checks++; if (strb !== 4'b0111) begin errors++; $display("FAIL rd00_strobe got=%b exp=0111", strb); end
    n = 0;
    while (nNMI !== 1'b1 && n < 3) begin cyc(1); n++; end
    checks++; if (nNMI !== 1'b1 || n > 2) begin errors++; $display("FAIL nmi_release got=%b after %0d clk exp=1 within 2", nNMI, n); end
    idle_bus(); cyc(2);
    m_en = 1; m_pend = 0;
  endtask

  task automatic test_set_wins();
    nSDW = 1'b0; cyc(2); nSDW = 1'b1; cyc(3);
    checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL pend_set got=%b exp=0", nNMI); end
    nSDW = 1'b0; cyc(2);
    start_io(1, 16'h0000); cyc(1);
    nSDW = 1'b1; cyc(1);
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL set_wins[%0d] got=%b exp=0", i, nNMI); end
    end
    io_cycle(1, 16'h0000, 1); cyc(3);
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL clear_after got=%b exp=1", nNMI); end
    m_pend = 0;
  endtask

  task automatic test_nmi_enable();
    io_cycle(0, 16'h0018, 1); cyc(2);
    nSDW = 1'b0; cyc(3); nSDW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL nmi_masked[%0d] got=%b exp=1", i, nNMI); end
    end
    start_io(0, 16'h0008); cyc(1);
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL en_lat1 got=%b exp=1", nNMI); end
    cyc(1);
    checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL en_lat2 got=%b exp=0", nNMI); end
    idle_bus(); cyc(2);
    io_cycle(0, 16'h0018, 1); cyc(1);
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL disable got=%b exp=1", nNMI); end
    io_cycle(0, 16'h0008, 1); cyc(1);
    checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL reenable got=%b exp=0", nNMI); end
    cyc(1);
    m_en = 1; m_pend = 1;
  endtask

  task automatic test_ym_strobes();
    start_io(0, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++; if (strb !== 4'b1110) begin errors++; $display("FAIL ym_cs[%0d] got=%b exp=1110", i, strb); end
      checks++; if (YM_A !== 2'b10) begin errors++; $display("FAIL ym_a[%0d] got=%b exp=10", i, YM_A); end
    end
    idle_bus(); cyc(1);
    checks++; if (strb !== 4'b1111) begin errors++; $display("FAIL ym_release got=%b exp=1111", strb); end
    start_io(1, 16'h00E5); cyc(1);
    checks++; if (strb !== 4'b1110 || YM_A !== 2'b01) begin errors++; $display("FAIL ym_rd_mirror got=%b/%b exp=1110/01", strb, YM_A); end
    idle_bus(); cyc(1);
    start_io(0, 16'h000C); cyc(1);
    checks++; if (strb !== 4'b1101) begin errors++; $display("FAIL reply_w got=%b exp=1101", strb); end
    idle_bus(); cyc(1);
    start_io(0, 16'h00E0); cyc(1);
    checks++; if (strb !== 4'b1011) begin errors++; $display("FAIL clr_mirror got=%b exp=1011", strb); end
    idle_bus(); cyc(1);
    start_io(0, 16'h0013); cyc(1);
    checks++; if (strb !== 4'b1111) begin errors++; $display("FAIL other_port got=%b exp=1111", strb); end
    idle_bus(); cyc(2);
    checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL nmi_untouched got=%b exp=0", nNMI); end
  endtask

  task automatic test_bank();
    io_cycle(1, 16'h2A0A, 2); cyc(1);
`ifdef SOUND_BANK_EN
    m_bank[2] = 8'h2A;
`endif
    checks++; if (banks !== exp_banks) begin errors++; $display("FAIL bank_2a0a got=%h exp=%h", banks, exp_banks); end
    io_cycle(1, 16'h55E8, 1); cyc(1);
`ifdef SOUND_BANK_EN
    m_bank[0] = 8'h55;
`endif
    checks++; if (banks !== exp_banks) begin errors++; $display("FAIL bank_mirror got=%h exp=%h", banks, exp_banks); end
    io_cycle(0, 16'h7709, 1); cyc(1);
    io_cycle(1, 16'h660C, 1); cyc(1);
    checks++; if (banks !== exp_banks) begin errors++; $display("FAIL bank_ignore got=%h exp=%h", banks, exp_banks); end
  endtask

  task automatic test_back_to_back();
    start_io(0, 16'h0018); cyc(2); idle_bus(); cyc(1);
    start_io(0, 16'h0008); cyc(2); idle_bus(); cyc(2);
    checks++; if (nNMI !== 1'b0) begin errors++; $display("FAIL b2b_en got=%b exp=0", nNMI); end
    start_io(0, 16'h0008); cyc(2); idle_bus(); cyc(1);
    start_io(0, 16'h0018); cyc(2); idle_bus(); cyc(2);
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL b2b_dis got=%b exp=1", nNMI); end
    start_io(1, 16'h1108); cyc(2); idle_bus(); cyc(1);
    start_io(1, 16'h2209); cyc(2); idle_bus(); cyc(1);
`ifdef SOUND_BANK_EN
    m_bank[0] = 8'h11; m_bank[1] = 8'h22;
`endif
    checks++; if (banks !== exp_banks) begin errors++; $display("FAIL b2b_bank got=%h exp=%h", banks, exp_banks); end
    m_en = 0;
  endtask

  task automatic test_reset_mid();
    start_io(0, 16'h0004); cyc(1);
    checks++; if (strb !== 4'b1110) begin errors++; $display("FAIL pre_reset got=%b exp=1110", strb); end
    nRESET = 1'b0; cyc(1);
    checks++; if (strb !== 4'b1111 || banks !== 32'h1E0E0602) begin errors++; $display("FAIL reset_forces got=%b/%h exp=1111/1e0e0602", strb, banks); end
    idle_bus();
    start_io(0, 16'h0008); cyc(1);
    nRESET = 1'b1; cyc(3); idle_bus(); cyc(2);
    model_reset();
    nSDW = 1'b0; cyc(2); nSDW = 1'b1; cyc(4);
    m_pend = 1;
    checks++; if (nNMI !== 1'b1) begin errors++; $display("FAIL stale_en got=%b exp=1", nNMI); end
    start_io(1, 16'h330B); cyc(1);
    nRESET = 1'b0; cyc(2); nRESET = 1'b1; cyc(3); idle_bus(); cyc(2);
    checks++; if (banks !== exp_banks) begin errors++; $display("FAIL stale_bank got=%h exp=%h", banks, exp_banks); end
    // reset cleared pend set above
    m_pend = 0;
  endtask

  task automatic test_random();
    int list [8] = '{0, 12, 4, 7, 8, 11, 24, 9};
    int p;
    bit rd;
    int hold;
    int gap;
    logic [15:0] a;
    logic [3:0]  e;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        nSDW = 1'b0; cyc(2); nSDW = 1'b1; cyc(2);
        m_pend = 1;
      end
      p    = ($urandom_range(0, 9) < 5) ? list[$urandom_range(0, 7)] : int'($urandom_range(0, 31));
      a    = {8'($urandom), 3'($urandom), 5'(p)};
      rd   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 4);
      gap  = $urandom_range(2, 3);
      e    = exp_strb(1, rd, a);
      start_io(rd, a);
      for (int h = 0; h < hold; h++) begin
        cyc(1);
        checks++; if (strb !== e) begin errors++; $display("FAIL rnd_strb t=%0d a=%h rd=%0d got=%b exp=%b", t, a, rd, strb, e); end
        if (!e[0]) begin
          checks++; if (YM_A !== a[1:0]) begin errors++; $display("FAIL rnd_ym_a t=%0d got=%b exp=%b", t, YM_A, a[1:0]); end
        end
      end
      idle_bus();
      if (!rd && p == 8)  m_en = 1;
      if (!rd && p == 24) m_en = 0;
      if (rd && p == 0)   m_pend = 0;
`ifdef SOUND_BANK_EN
      if (rd && p >= 8 && p <= 11) m_bank[p - 8] = a[15:8];
`endif
      cyc(1);
      checks++; if (strb !== 4'b1111) begin errors++; $display("FAIL rnd_idle t=%0d got=%b exp=1111", t, strb); end
      cyc(gap - 1);
      checks++; if (nNMI !== !(m_pend && m_en)) begin errors++; $display("FAIL rnd_nmi t=%0d got=%b exp=%b", t, nNMI, !(m_pend && m_en)); end
      checks++; if (banks !== exp_banks) begin errors++; $display("FAIL rnd_bank t=%0d got=%h exp=%h", t, banks, exp_banks); end
    end
  endtask

  initial begin
    test_reset();
    test_nmi_basic();
    test_set_wins();
    test_nmi_enable();
    test_ym_strobes();
    test_bank();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
